// File: rtl/config_chain_pkg.sv
// Shared types and sizing helpers for the configuration chain loader.
package config_chain_pkg;

   // Loader FSM states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Words needed per load: ceil(chain_len / word_w).
   function automatic int calc_n(input int chain_len, input int word_w);
      return (chain_len + word_w - 1) / word_w;
   endfunction

   // Bits taken from word 0 (1..word_w); the remaining words are full.
   function automatic int calc_r(input int chain_len, input int word_w);
      return chain_len - (calc_n(chain_len, word_w) - 1) * word_w;
   endfunction

   // Counter width able to hold values 0..v-1 (never narrower than 1 bit).
   function automatic int cnt_w(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/config_rb_packer.sv
// Packs bits leaving the chain tail into readback words using the same
// framing as the write stream: R bits in word 0, then WORD_W bits per word.
module config_rb_packer
   import config_chain_pkg::*;
#(
   parameter int CHAIN_LEN = 7,
   parameter int WORD_W    = 8
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clear,
   input  logic              i_en,
   input  logic              i_bit,
   output logic [WORD_W-1:0] o_rb_word,
   output logic              o_rb_valid
);

   localparam int R    = calc_r(CHAIN_LEN, WORD_W);
   localparam int BC_W = cnt_w(WORD_W);
   localparam logic [BC_W-1:0] R_M1 = BC_W'(R - 1);
   localparam logic [BC_W-1:0] W_M1 = BC_W'(WORD_W - 1);

   logic [WORD_W-1:0] r_cap;
   logic [BC_W-1:0]   r_cnt;
   logic              r_first;
   logic [WORD_W-1:0] w_cap_nxt;
   logic [BC_W-1:0]   w_cnt_last;
   logic              w_word_end;

   // Word 0 starts from a cleared register, so its unused upper bits stay 0.
   assign w_cap_nxt  = (r_cap << 1) | WORD_W'(i_bit);
   assign w_cnt_last = r_first ? R_M1 : W_M1;
   assign w_word_end = (r_cnt == w_cnt_last);

   // Capture on every enabled shift; emit a word when its last bit arrives.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cap      <= '0;
         r_cnt      <= '0;
         r_first    <= 1'b1;
         o_rb_word  <= '0;
         o_rb_valid <= 1'b0;
      end else begin
         o_rb_valid <= 1'b0;
         if (i_clear) begin
            r_cap   <= '0;
            r_cnt   <= '0;
            r_first <= 1'b1;
         end else if (i_en) begin
            if (w_word_end) begin
               o_rb_word  <= w_cap_nxt;
               o_rb_valid <= 1'b1;
               r_cap      <= '0;
               r_cnt      <= '0;
               r_first    <= 1'b0;
            end else begin
               r_cap <= w_cap_nxt;
               r_cnt <= r_cnt + BC_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/config_chain_loader.sv
// Serial configuration chain writer. Shifts CHAIN_LEN bits into the chain,
// MSB first, fed from a word stream, and reads the old contents back.
//
// Handshake: a word transfers on a rising edge where cfg_valid and cfg_ready
// are both high. cfg_ready is high in FETCH and in the last SHIFT cycle of a
// word when more words remain; cfg_valid is ignored at any other time and
// the source may drop it freely (the chain simply holds while it waits).
module config_chain_loader
   import config_chain_pkg::*;
#(
   parameter int CHAIN_LEN = 7,
   parameter int WORD_W    = 8
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WORD_W-1:0] cfg_word,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              configuration_input,
   output logic              configuration_enable,
   input  logic              configuration_output,
   output logic [WORD_W-1:0] rb_word,
   output logic              rb_valid,
   output logic              busy,
   output logic              done,
   output logic [1:0]        dbg_state
);

   localparam int N    = calc_n(CHAIN_LEN, WORD_W);
   localparam int R    = calc_r(CHAIN_LEN, WORD_W);
   localparam int BC_W = cnt_w(WORD_W);
   localparam int WC_W = cnt_w(N + 1);
   localparam logic [BC_W-1:0] R_M1  = BC_W'(R - 1);
   localparam logic [BC_W-1:0] W_M1  = BC_W'(WORD_W - 1);
   localparam logic [WC_W-1:0] WORDS = WC_W'(N);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WORD_W-1:0] r_shreg;
   logic [BC_W-1:0]   r_bits_left;   // bits of current word still to send after this one
   logic [WC_W-1:0]   r_word_idx;    // index of the next word to fetch
   logic              r_cin;
   logic              r_cen;
   logic              r_busy;
   logic              r_done;
   logic              w_hs;
   logic              w_ready;
   logic              w_last_bit;
   logic              w_more;
   logic              w_load_start;
   logic [WORD_W-1:0] w_aligned;

   assign w_last_bit   = (r_bits_left == '0);
   assign w_more       = (r_word_idx != WORDS);
   assign w_load_start = (r_state == ST_IDLE) && start;

   // Word 0 only contributes its low R bits; move them to the top so every
   // word leaves MSB first from bit WORD_W-1.
   assign w_aligned = (r_word_idx == '0) ? (cfg_word << (WORD_W - R)) : cfg_word;

   // Next-state and handshake decode.
   always_comb begin
      w_state_nxt = r_state;
      w_hs        = 1'b0;
      w_ready     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            w_ready = 1'b1;
            if (cfg_valid) begin
               w_hs        = 1'b1;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (w_last_bit) begin
               if (!w_more) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_ready = 1'b1;
                  if (cfg_valid) w_hs = 1'b1;
                  else           w_state_nxt = ST_FETCH;
               end
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, counters and the serial output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_shreg     <= '0;
         r_bits_left <= '0;
         r_word_idx  <= '0;
         r_cin       <= 1'b0;
         r_cen       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != ST_IDLE);
         r_done  <= (w_state_nxt == ST_DONE);
         if (w_load_start) r_word_idx <= '0;
         if (w_hs) begin
            r_cin       <= w_aligned[WORD_W-1];
            r_shreg     <= w_aligned << 1;
            r_bits_left <= (r_word_idx == '0) ? R_M1 : W_M1;
            r_word_idx  <= r_word_idx + WC_W'(1);
            r_cen       <= 1'b1;
         end else if ((r_state == ST_SHIFT) && !w_last_bit) begin
            r_cin       <= r_shreg[WORD_W-1];
            r_shreg     <= r_shreg << 1;
            r_bits_left <= r_bits_left - BC_W'(1);
            r_cen       <= 1'b1;
         end else begin
            r_cin <= 1'b0;
            r_cen <= 1'b0;
         end
      end
   end

   config_rb_packer #(
      .CHAIN_LEN (CHAIN_LEN),
      .WORD_W    (WORD_W)
   ) u_rb_packer (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (w_load_start),
      .i_en       (r_cen),
      .i_bit      (configuration_output),
      .o_rb_word  (rb_word),
      .o_rb_valid (rb_valid)
   );

   assign cfg_ready            = w_ready;
   assign configuration_input  = r_cin;
   assign configuration_enable = r_cen;
   assign busy                 = r_busy;
   assign done                 = r_done;
   assign dbg_state            = r_state;

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader. Three instances cover
// 7/8, 20/8 and 8/8 chains; sel picks which one is driven and observed.
module tb_config_chain_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       cfg_valid;
   logic [7:0] cfg_word;
   logic [1:0] sel;

   logic [2:0] st_g, vl_g, rdy, cin, cen, rbv, bsy, dn, tail;
   logic [7:0] rbw [3];
   logic [1:0] dbg [3];

   logic [6:0]  ch0 = '0;
   logic [19:0] ch1 = '0;
   logic [7:0]  ch2 = '0;

   logic       m_ready, m_cin, m_cen, m_rbv, m_busy, m_done;
   logic [7:0] m_rbw;
   logic [1:0] m_dbg;

   int n_checks = 0;
   int n_errors = 0;

   int   cyc = 0;
   int   en_cnt, done_cnt, hs_cnt, first_en, last_en, done_cyc, last_rb, busy_fall, run, max_run;
   logic busy_prev = 1'b0;
   logic cin_q [$];
   logic [7:0] rb_q [$];
   logic [7:0] exp_q [$];

   // Clock
   always #5 clk = ~clk;

   assign st_g = {3{start}} & (3'b001 << sel);
   assign vl_g = {3{cfg_valid}} & (3'b001 << sel);
   assign tail = {ch2[7], ch1[19], ch0[6]};

   config_chain_loader #(.CHAIN_LEN(7), .WORD_W(8)) u_dut0 (
      .clk(clk), .rst(rst), .start(st_g[0]), .cfg_word(cfg_word), .cfg_valid(vl_g[0]),
      .cfg_ready(rdy[0]), .configuration_input(cin[0]), .configuration_enable(cen[0]),
      .configuration_output(tail[0]), .rb_word(rbw[0]), .rb_valid(rbv[0]),
      .busy(bsy[0]), .done(dn[0]), .dbg_state(dbg[0]));

   config_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_dut1 (
      .clk(clk), .rst(rst), .start(st_g[1]), .cfg_word(cfg_word), .cfg_valid(vl_g[1]),
      .cfg_ready(rdy[1]), .configuration_input(cin[1]), .configuration_enable(cen[1]),
      .configuration_output(tail[1]), .rb_word(rbw[1]), .rb_valid(rbv[1]),
      .busy(bsy[1]), .done(dn[1]), .dbg_state(dbg[1]));

   config_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) u_dut2 (
      .clk(clk), .rst(rst), .start(st_g[2]), .cfg_word(cfg_word), .cfg_valid(vl_g[2]),
      .cfg_ready(rdy[2]), .configuration_input(cin[2]), .configuration_enable(cen[2]),
      .configuration_output(tail[2]), .rb_word(rbw[2]), .rb_valid(rbv[2]),
      .busy(bsy[2]), .done(dn[2]), .dbg_state(dbg[2]));

   // Behavioural chains: plain shift registers gated by enable, tail at the top.
   always @(posedge clk) if (cen[0]) ch0 <= {ch0[5:0], cin[0]};
   always @(posedge clk) if (cen[1]) ch1 <= {ch1[18:0], cin[1]};
   always @(posedge clk) if (cen[2]) ch2 <= {ch2[6:0], cin[2]};

   // Observe the selected instance.
   always_comb begin
      m_ready = rdy[sel];
      m_cin   = cin[sel];
      m_cen   = cen[sel];
      m_rbv   = rbv[sel];
      m_busy  = bsy[sel];
      m_done  = dn[sel];
      m_rbw   = rbw[sel];
      m_dbg   = dbg[sel];
   end

   // Monitor, sampled mid-cycle.
   always @(negedge clk) begin
      cyc++;
      if (m_cen) begin
         en_cnt++;
         cin_q.push_back(m_cin);
         if (first_en < 0) first_en = cyc;
         last_en = cyc;
         run++;
         if (run > max_run) max_run = run;
      end else begin
         run = 0;
      end
      if (m_rbv) begin
         rb_q.push_back(m_rbw);
         last_rb = cyc;
      end
      if (m_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (m_ready && cfg_valid) hs_cnt++;
      if (!m_busy && busy_prev) busy_fall = cyc;
      busy_prev = m_busy;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      en_cnt = 0; done_cnt = 0; hs_cnt = 0; run = 0; max_run = 0;
      first_en = -1; last_en = -1; done_cyc = -1; last_rb = -1; busy_fall = -1;
      cin_q.delete();
      rb_q.delete();
   endtask

   task automatic start_pulse();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_after_start", m_busy, 1);
      check("ready_in_fetch", m_ready, 1);
   endtask

   // Offer one word; hold cfg_valid low for the first 'stall' cycles the DUT is ready.
   task automatic send_word(input logic [7:0] w, input int stall);
      int   seen = 0;
      int   guard = 0;
      logic got = 1'b0;
      logic r, v;
      cfg_word  = w;
      cfg_valid = (stall == 0);
      while (!got && guard < 100) begin
         r = m_ready;
         v = cfg_valid;
         tick();
         guard++;
         if (r && v) got = 1'b1;
         else if (r) begin
            seen++;
            if (seen >= stall) cfg_valid = 1'b1;
         end
      end
      cfg_valid = 1'b0;
      check("handshake", got, 1);
   endtask

   task automatic wait_idle();
      int g = 0;
      while (m_busy && g < 100) begin
         tick();
         g++;
      end
      check("load_finished", m_busy, 0);
      tick();
      tick();
   endtask

   task automatic do_load(input int nw, input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input int stall1);
      start_pulse();
      send_word(w0, 0);
      if (nw > 1) send_word(w1, stall1);
      if (nw > 2) send_word(w2, 0);
      wait_idle();
   endtask

   task automatic check_timing();
      check("done_count", done_cnt, 1);
      check("done_after_last_en", done_cyc, last_en + 1);
      check("last_rb_with_done", last_rb, done_cyc);
      check("busy_falls_after_done", busy_fall, done_cyc + 1);
   endtask

   task automatic exp3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      exp_q.delete();
      exp_q.push_back(a);
      exp_q.push_back(b);
      exp_q.push_back(c);
   endtask

   task automatic check_rb();
      check("rb_count", rb_q.size(), exp_q.size());
      while (exp_q.size() > 0 && rb_q.size() > 0)
         check("rb_word", rb_q.pop_front(), exp_q.pop_front());
      exp_q.delete();
   endtask

   initial begin
      logic [6:0] bits55;
      bits55    = 7'b1010101;
      sel       = 2'd0;
      rst       = 1'b1;
      start     = 1'b0;
      cfg_valid = 1'b0;
      cfg_word  = 8'h00;
      clear_mon();
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state
      check("rst_ready", m_ready, 0);
      check("rst_cin", m_cin, 0);
      check("rst_cen", m_cen, 0);
      check("rst_busy", m_busy, 0);
      check("rst_done", m_done, 0);
      check("rst_rb_valid", m_rbv, 0);
      check("rst_rb_word", m_rbw, 0);
      check("rst_state", m_dbg, 0);

      // 7/8 chain, single word 0x55
      clear_mon();
      do_load(1, 8'h55, 8'h00, 8'h00, 0);
      check("t1_en_cnt", en_cnt, 7);
      check("t1_cin_len", cin_q.size(), 7);
      for (int i = 0; i < 7; i++)
         if (i < cin_q.size()) check("t1_cin_bit", cin_q[i], bits55[6-i]);
      check("t1_chain", ch0, 7'h55);
      check("t1_far_end", ch0[6], 1);
      check_timing();
      exp_q.delete();
      exp_q.push_back(8'h00);
      check_rb();

      // 20/8 chain: load 0A BC DE, then zeros to read it back
      sel = 2'd1;
      tick();
      clear_mon();
      do_load(3, 8'h0A, 8'hBC, 8'hDE, 0);
      check("t2a_en_cnt", en_cnt, 20);
      check("t2a_en_run", max_run, 20);
      check("t2a_chain", ch1, 20'hABCDE);
      check_timing();
      exp3(8'h00, 8'h00, 8'h00);
      check_rb();

      clear_mon();
      do_load(3, 8'h00, 8'h00, 8'h00, 0);
      check("t2b_en_run", max_run, 20);
      check("t2b_chain", ch1, 20'h00000);
      check_timing();
      exp3(8'h0A, 8'hBC, 8'hDE);
      check_rb();

      // Stall of 5 ready cycles before word 1; word 0 upper bits must be ignored
      clear_mon();
      do_load(3, 8'hFA, 8'hBC, 8'hDE, 5);
      check("t3_en_cnt", en_cnt, 20);
      check("t3_stall_gap", (last_en - first_en + 1) - 20, 5);
      check("t3_hs_cnt", hs_cnt, 3);
      check("t3_chain", ch1, 20'hABCDE);
      check_timing();
      exp3(8'h00, 8'h00, 8'h00);
      check_rb();

      // Reset after three enable cycles
      clear_mon();
      start_pulse();
      send_word(8'h03, 0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t4_cen_after_rst", m_cen, 0);
      check("t4_busy_after_rst", m_busy, 0);
      check("t4_ready_after_rst", m_ready, 0);
      check("t4_state_after_rst", m_dbg, 0);
      repeat (5) tick();
      check("t4_en_cnt", en_cnt, 3);
      check("t4_no_done", done_cnt, 0);
      check("t4_no_rb", rb_q.size(), 0);
      check("t4_chain", ch1, 20'h5E6F1);
      clear_mon();
      do_load(3, 8'h0A, 8'hBC, 8'hDE, 0);
      check("t4_reload_en", en_cnt, 20);
      check("t4_reload_chain", ch1, 20'hABCDE);
      check_timing();
      exp3(8'h05, 8'hE6, 8'hF1);
      check_rb();

      // cfg_valid in IDLE, start while busy
      clear_mon();
      cfg_word  = 8'h77;
      cfg_valid = 1'b1;
      repeat (4) tick();
      check("t5_idle_ready", m_ready, 0);
      cfg_valid = 1'b0;
      check("t5_idle_hs", hs_cnt, 0);
      check("t5_idle_busy", m_busy, 0);
      fork
         do_load(3, 8'h0A, 8'hBC, 8'hDE, 0);
         begin
            repeat (8) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
         end
      join
      repeat (5) tick();
      check("t5_done_cnt", done_cnt, 1);
      check("t5_en_cnt", en_cnt, 20);
      check("t5_hs_cnt", hs_cnt, 3);
      check("t5_idle_after", m_busy, 0);
      check("t5_chain", ch1, 20'hABCDE);
      exp3(8'h0A, 8'hBC, 8'hDE);
      check_rb();

      // 8/8 chain, R = 8
      sel = 2'd2;
      tick();
      clear_mon();
      do_load(1, 8'hFF, 8'h00, 8'h00, 0);
      check("t6a_chain", ch2, 8'hFF);
      exp_q.push_back(8'h00);
      check_rb();
      clear_mon();
      do_load(1, 8'h01, 8'h00, 8'h00, 0);
      check("t6b_en_cnt", en_cnt, 8);
      check("t6b_chain", ch2, 8'h01);
      check_timing();
      exp_q.push_back(8'hFF);
      check_rb();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
